pipe_ctrl: RTL

Pipeline stall/flush controller for the 5-stage core. It sequences the IF/ID and ID/EX pipeline registers. It detects load-use hazards and inserts a bubble into ID/EX. It flushes IF/ID and ID/EX on a taken branch resolved in EX, and freezes the front end while a multi-cycle EX operation (divider) runs for a fixed cycle count. It also keeps a saturating stalled-cycle counter for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_if.sv | 47 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 26 ++
 rtl/pipe_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Register address bus, NOP encodings and controller state.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t NOP_REG_ADDR = '0;
  localparam logic      ENABLED      = 1'b1;
  localparam logic      DISABLED     = 1'b0;

  typedef enum logic {
    CTRL_RUN = 1'b0,
    CTRL_MC  = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic bubble_idex;
    logic flush_ifid;
    logic mc_busy;
    logic mc_last;
  } ctrl_out_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID/EX status in, pipeline control out.
// The controller takes the slave side.
interface pipe_ctrl_if #(
  parameter int PERF_W = 32
) ();
  import pipe_ctrl_pkg::*;

  reg_addr_t         id_reg1addr;
  logic              id_reg1en;
  reg_addr_t         id_reg2addr;
  logic              id_reg2en;
  reg_addr_t         ex_rd;
  logic              ex_regwe;
  logic              ex_is_load;
  logic              ex_mc_start;
  logic              ex_branch_taken;

  logic              stall_pc;
  logic              stall_ifid;
  logic              stall_idex;
  logic              bubble_idex;
  logic              flush_ifid;
  logic              mc_busy;
  logic              mc_last;
  logic [PERF_W-1:0] stall_count;

  modport master (
    output id_reg1addr, id_reg1en,
    output id_reg2addr, id_reg2en,
    output ex_rd, ex_regwe, ex_is_load,
    output ex_mc_start, ex_branch_taken,
    input  stall_pc, stall_ifid, stall_idex,
    input  bubble_idex, flush_ifid,
    input  mc_busy, mc_last, stall_count
  );

  modport slave (
    input  id_reg1addr, id_reg1en,
    input  id_reg2addr, id_reg2en,
    input  ex_rd, ex_regwe, ex_is_load,
    input  ex_mc_start, ex_branch_taken,
    output stall_pc, stall_ifid, stall_idex,
    output bubble_idex, flush_ifid,
    output mc_busy, mc_last, stall_count
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in flight writes a register
// that the consuming stage is about to read.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic      ex_is_load,
  input  logic      ex_regwe,
  input  reg_addr_t ex_rd,
  input  logic      id_reg1en,
  input  reg_addr_t id_reg1addr,
  input  logic      id_reg2en,
  input  reg_addr_t id_reg2addr,
  output logic      hz
);

  logic src1_hit;
  logic src2_hit;
  logic ld_live;

  assign ld_live  = ex_is_load & ex_regwe
                  & (ex_rd != NOP_REG_ADDR);
  assign src1_hit = id_reg1en & (id_reg1addr == ex_rd);
  assign src2_hit = id_reg2en & (id_reg2addr == ex_rd);
  assign hz       = ld_live & (src1_hit | src2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencing for IF/ID and ID/EX, multi-cycle
// EX freeze, and a saturating stalled-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6,
  parameter int PERF_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MC_LOAD =
    CNT_W'(MC_CYCLES - 1);

  ctrl_state_e       state;
  ctrl_state_e       state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PERF_W-1:0] stall_count;
  ctrl_out_t         o;
  logic              hz;

  pipe_ctrl_hazard_detect u_hz (
    .ex_is_load  (bus.ex_is_load),
    .ex_regwe    (bus.ex_regwe),
    .ex_rd       (bus.ex_rd),
    .id_reg1en   (bus.id_reg1en),
    .id_reg1addr (bus.id_reg1addr),
    .id_reg2en   (bus.id_reg2en),
    .id_reg2addr (bus.id_reg2addr),
    .hz          (hz)
  );

  always_comb begin
    o         = '0;
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      CTRL_RUN: begin
        // The branch itself sits in EX, so it wins over
        // anything the younger instructions ask for.
        if (bus.ex_branch_taken) begin
          o.flush_ifid  = 1'b1;
          o.bubble_idex = 1'b1;
        end else if (bus.ex_mc_start) begin
          if (MC_CYCLES == 1) begin
            o.mc_last = 1'b1;
          end else begin
            o.stall_pc   = 1'b1;
            o.stall_ifid = 1'b1;
            o.stall_idex = 1'b1;
            o.mc_busy    = 1'b1;
            state_nxt    = CTRL_MC;
            cnt_nxt      = MC_LOAD;
          end
        end else if (hz) begin
          o.stall_pc    = 1'b1;
          o.stall_ifid  = 1'b1;
          o.bubble_idex = 1'b1;
        end
      end
      CTRL_MC: begin
        if (cnt != '0) begin
          o.stall_pc   = 1'b1;
          o.stall_ifid = 1'b1;
          o.stall_idex = 1'b1;
          o.mc_busy    = 1'b1;
          cnt_nxt      = cnt - CNT_W'(1);
        end else begin
          o.mc_last = 1'b1;
          state_nxt = CTRL_RUN;
        end
      end
      default: begin
        state_nxt = CTRL_RUN;
      end
    endcase
    if (!rst) begin
      o = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CTRL_RUN;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (o.stall_pc && (stall_count != '1)) begin
        stall_count <= stall_count + PERF_W'(1);
      end
    end
  end

  assign bus.stall_pc    = o.stall_pc;
  assign bus.stall_ifid  = o.stall_ifid;
  assign bus.stall_idex  = o.stall_idex;
  assign bus.bubble_idex = o.bubble_idex;
  assign bus.flush_ifid  = o.flush_ifid;
  assign bus.mc_busy     = o.mc_busy;
  assign bus.mc_last     = o.mc_last;
  assign bus.stall_count = stall_count;

endmodule
